// File: rtl/apb_slave_mem.sv
// APB completer with a 256 x 8 register file. It inserts a fixed number of
// wait states and flags write-protected or protocol-violating accesses on
// PSLVERR. Read data, PREADY and PSLVERR all come straight from registers.
module apb_slave_mem #(
  parameter int         WAIT_STATES  = 2,
  parameter logic [8:0] PROTECT_BASE = 9'd256
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] cnt;
  logic       viol;
  logic [7:0] lat_addr;
  logic       lat_write;
  logic [7:0] lat_wdata;
  logic [7:0] mem [256];

  logic       setup_phase;
  logic       access_phase;
  logic       mismatch;
  logic [3:0] cnt_dec;
  logic       go_done;
  logic [7:0] done_addr;
  logic       done_write;
  logic       done_viol;
  logic       done_err;
  logic [7:0] done_rdata;

  assign setup_phase  = PSEL & ~PENABLE;
  assign access_phase = PSEL & PENABLE;
  assign cnt_dec      = cnt - 4'd1;
  assign mismatch     = (PADDR != lat_addr) | (PWRITE != lat_write) |
                        (lat_write & (PWDATA != lat_wdata));

  // Decide whether this edge enters DONE and, if so, which address/direction
  // and error state the response is built from (live bus values on a setup
  // or illegal access, latched values at the end of the wait countdown).
  always_comb begin
    go_done    = 1'b0;
    done_addr  = lat_addr;
    done_write = lat_write;
    done_viol  = viol | mismatch;
    if (setup_phase) begin
      go_done    = (WS == 4'd0);
      done_addr  = PADDR;
      done_write = PWRITE;
      done_viol  = 1'b0;
    end else if (state == IDLE && access_phase) begin
      go_done    = 1'b1;
      done_addr  = PADDR;
      done_write = PWRITE;
      done_viol  = 1'b1;
    end else if (state == WAIT && access_phase) begin
      go_done    = (cnt_dec == 4'd0);
    end
    done_err   = done_viol | (done_write & ({1'b0, done_addr} >= PROTECT_BASE));
    done_rdata = mem[done_addr];
  end

  // Transfer FSM, memory and registered response; reset clears everything.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      viol      <= 1'b0;
      lat_addr  <= 8'h00;
      lat_write <= 1'b0;
      lat_wdata <= 8'h00;
      PRDATA    <= 8'h00;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (setup_phase) begin
        lat_addr  <= PADDR;
        lat_write <= PWRITE;
        lat_wdata <= PWDATA;
        cnt       <= WS;
        viol      <= 1'b0;
        state     <= WAIT;
        PREADY    <= 1'b0;
        PSLVERR   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (access_phase) begin
              lat_addr  <= PADDR;
              lat_write <= PWRITE;
              lat_wdata <= PWDATA;
              viol      <= 1'b1;
            end
          end
          WAIT: begin
            if (!PSEL) begin
              state <= IDLE;
            end else begin
              cnt  <= cnt_dec;
              viol <= viol | mismatch;
            end
          end
          DONE: begin
            if (access_phase && PREADY && lat_write && !PSLVERR) begin
              mem[lat_addr] <= lat_wdata;
            end
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
      if (go_done) begin
        state   <= DONE;
        PREADY  <= 1'b1;
        PSLVERR <= done_err;
        if (!done_write) begin
          PRDATA <= done_err ? 8'h00 : done_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances with different wait-state and
// protection settings share one APB bus, each with its own PSEL.
module tb_apb_slave_mem;

  logic       PCLK;
  logic       PRESET;
  logic       psel_a, psel_b, psel_c;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] prdata_a, prdata_b, prdata_c;
  logic       pready_a, pready_b, pready_c;
  logic       pslverr_a, pslverr_b, pslverr_c;

  typedef struct {
    string      name;
    int         ready;
    logic       err;
    logic [7:0] data;
    bit         chk;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  int    n_checks;
  int    n_fail;
  int    cyc;

  apb_slave_mem #(.WAIT_STATES(2), .PROTECT_BASE(9'h0F0)) dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

  apb_slave_mem #(.WAIT_STATES(3), .PROTECT_BASE(9'd256)) dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

  apb_slave_mem #(.WAIT_STATES(0), .PROTECT_BASE(9'h080)) dut_c (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_c), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata_c), .PREADY(pready_c), .PSLVERR(pslverr_c));

  // Free-running clock and cycle counter.
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  initial cyc = 0;
  always @(posedge PCLK) cyc = cyc + 1;

  // Drive one complete transfer on instance sel (0=a, 1=b, 2=c) and push the
  // observed access cycle of PREADY, PSLVERR and PRDATA onto obs_q.
  task automatic run_xfer(input int sel, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input int chg_cycle,
                          input logic [7:0] chg_addr, input bit b2b);
    int         k;
    int         rc;
    logic       rdy;
    logic       er;
    logic [7:0] dt;
    if (!b2b) begin
      @(posedge PCLK); #1;
    end
    psel_a = (sel == 0); psel_b = (sel == 1); psel_c = (sel == 2);
    PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    k = 1; rc = 0; er = 1'bx; dt = 8'hxx;
    if (chg_cycle == 1) PADDR = chg_addr;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      case (sel)
        0:       begin rdy = pready_a; er = pslverr_a; dt = prdata_a; end
        1:       begin rdy = pready_b; er = pslverr_b; dt = prdata_b; end
        default: begin rdy = pready_c; er = pslverr_c; dt = prdata_c; end
      endcase
      if (rdy === 1'b1) begin
        rc = k;
        break;
      end
      @(posedge PCLK); #1;
      k++;
      if (k == chg_cycle) PADDR = chg_addr;
    end
    @(posedge PCLK); #1;
    psel_a = 1'b0; psel_b = 1'b0; psel_c = 1'b0; PENABLE = 1'b0;
    obs_q.push_back('{name: "", ready: rc, err: er, data: dt, chk: 1'b0});
  endtask

  task automatic test_reset();
    xfer_t e, o;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if (pready_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pready got %b expected 0", pready_a); end
    n_checks++;
    if (pslverr_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pslverr got %b expected 0", pslverr_a); end
    n_checks++;
    if (prdata_a !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_prdata got %h expected 00", prdata_a); end
    exp_q.push_back('{name: "rst_rd10", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(0, 1'b0, 8'h10, 8'h00, 0, 8'h00, 1'b0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ready !== e.ready) begin n_fail++; $display("[TB] FAIL %s ready_cycle got %0d expected %0d", e.name, o.ready, e.ready); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, o.err, e.err); end
      if (e.chk) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, o.data, e.data); end
      end
    end
  endtask

  task automatic test_write_read();
    xfer_t e, o;
    exp_q.push_back('{name: "wr10_a5", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b0});
    run_xfer(0, 1'b1, 8'h10, 8'hA5, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "rd10", ready: 3, err: 1'b0, data: 8'hA5, chk: 1'b1});
    run_xfer(0, 1'b0, 8'h10, 8'h00, 0, 8'h00, 1'b0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ready !== e.ready) begin n_fail++; $display("[TB] FAIL %s ready_cycle got %0d expected %0d", e.name, o.ready, e.ready); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, o.err, e.err); end
      if (e.chk) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, o.data, e.data); end
      end
    end
  endtask

  task automatic test_protected();
    xfer_t e, o;
    exp_q.push_back('{name: "wrF4_prot", ready: 3, err: 1'b1, data: 8'h00, chk: 1'b0});
    run_xfer(0, 1'b1, 8'hF4, 8'h3C, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "rdF4", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(0, 1'b0, 8'hF4, 8'h00, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "wrEF_below", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b0});
    run_xfer(0, 1'b1, 8'hEF, 8'h11, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "wrF0_base", ready: 3, err: 1'b1, data: 8'h00, chk: 1'b0});
    run_xfer(0, 1'b1, 8'hF0, 8'h22, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "rdF0", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(0, 1'b0, 8'hF0, 8'h00, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "rdEF", ready: 3, err: 1'b0, data: 8'h11, chk: 1'b1});
    run_xfer(0, 1'b0, 8'hEF, 8'h00, 0, 8'h00, 1'b0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ready !== e.ready) begin n_fail++; $display("[TB] FAIL %s ready_cycle got %0d expected %0d", e.name, o.ready, e.ready); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, o.err, e.err); end
      if (e.chk) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, o.data, e.data); end
      end
    end
  endtask

  task automatic test_mid_change();
    xfer_t e, o;
    exp_q.push_back('{name: "wr20_chg", ready: 4, err: 1'b1, data: 8'h00, chk: 1'b0});
    run_xfer(1, 1'b1, 8'h20, 8'h77, 2, 8'h21, 1'b0);
    exp_q.push_back('{name: "rd20_b", ready: 4, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(1, 1'b0, 8'h20, 8'h00, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "rd21_b", ready: 4, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(1, 1'b0, 8'h21, 8'h00, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "wrFF_b", ready: 4, err: 1'b0, data: 8'h00, chk: 1'b0});
    run_xfer(1, 1'b1, 8'hFF, 8'h66, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "rdFF_b", ready: 4, err: 1'b0, data: 8'h66, chk: 1'b1});
    run_xfer(1, 1'b0, 8'hFF, 8'h00, 0, 8'h00, 1'b0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ready !== e.ready) begin n_fail++; $display("[TB] FAIL %s ready_cycle got %0d expected %0d", e.name, o.ready, e.ready); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, o.err, e.err); end
      if (e.chk) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, o.data, e.data); end
      end
    end
  endtask

  task automatic test_zero_wait();
    xfer_t e, o;
    exp_q.push_back('{name: "c_wr05", ready: 1, err: 1'b0, data: 8'h00, chk: 1'b0});
    run_xfer(2, 1'b1, 8'h05, 8'h9A, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "c_rd05", ready: 1, err: 1'b0, data: 8'h9A, chk: 1'b1});
    run_xfer(2, 1'b0, 8'h05, 8'h00, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "c_wr80_prot", ready: 1, err: 1'b1, data: 8'h00, chk: 1'b0});
    run_xfer(2, 1'b1, 8'h80, 8'h5E, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "c_wr06_chg", ready: 1, err: 1'b0, data: 8'h00, chk: 1'b0});
    run_xfer(2, 1'b1, 8'h06, 8'h44, 1, 8'h07, 1'b0);
    exp_q.push_back('{name: "c_rd06", ready: 1, err: 1'b0, data: 8'h44, chk: 1'b1});
    run_xfer(2, 1'b0, 8'h06, 8'h00, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "c_rd07", ready: 1, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(2, 1'b0, 8'h07, 8'h00, 0, 8'h00, 1'b0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ready !== e.ready) begin n_fail++; $display("[TB] FAIL %s ready_cycle got %0d expected %0d", e.name, o.ready, e.ready); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, o.err, e.err); end
      if (e.chk) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, o.data, e.data); end
      end
    end
  endtask

  task automatic test_illegal();
    xfer_t e;
    @(posedge PCLK); #1;
    psel_a = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h10; PWDATA = 8'h00;
    exp_q.push_back('{name: "illegal", ready: 1, err: 1'b1, data: 8'h00, chk: 1'b1});
    @(negedge PCLK);
    n_checks++;
    if (pready_a !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_pre_pready got %b expected 0", pready_a); end
    @(negedge PCLK);
    e = exp_q.pop_front();
    n_checks++;
    if (pready_a !== 1'(e.ready)) begin n_fail++; $display("[TB] FAIL %s pready got %b expected %0d", e.name, pready_a, e.ready); end
    n_checks++;
    if (pslverr_a !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, pslverr_a, e.err); end
    n_checks++;
    if (prdata_a !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, prdata_a, e.data); end
    @(posedge PCLK); #1;
    psel_a = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_back_to_back();
    xfer_t e, o;
    int    c0;
    c0 = cyc;
    exp_q.push_back('{name: "b2b_wr40", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b0});
    run_xfer(0, 1'b1, 8'h40, 8'h5A, 0, 8'h00, 1'b1);
    exp_q.push_back('{name: "b2b_rd40", ready: 3, err: 1'b0, data: 8'h5A, chk: 1'b1});
    run_xfer(0, 1'b0, 8'h40, 8'h00, 0, 8'h00, 1'b1);
    n_checks++;
    if (cyc - c0 !== 8) begin n_fail++; $display("[TB] FAIL b2b_cycles got %0d expected 8", cyc - c0); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ready !== e.ready) begin n_fail++; $display("[TB] FAIL %s ready_cycle got %0d expected %0d", e.name, o.ready, e.ready); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, o.err, e.err); end
      if (e.chk) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, o.data, e.data); end
      end
    end
  endtask

  task automatic test_abort();
    xfer_t e, o;
    bit    seen;
    // Abort by dropping PSEL in access cycle 1.
    seen = 1'b0;
    @(posedge PCLK); #1;
    psel_a = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h30; PWDATA = 8'h55;
    @(posedge PCLK); #1;
    psel_a = 1'b0;
    repeat (5) begin
      @(negedge PCLK);
      if (pready_a === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_pready got 1 expected 0"); end
    exp_q.push_back('{name: "abort_rd30", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(0, 1'b0, 8'h30, 8'h00, 0, 8'h00, 1'b0);
    // Leave PRDATA non-zero, then reset in the middle of a WAIT.
    exp_q.push_back('{name: "pre_rst_rd10", ready: 3, err: 1'b0, data: 8'hA5, chk: 1'b1});
    run_xfer(0, 1'b0, 8'h10, 8'h00, 0, 8'h00, 1'b0);
    seen = 1'b0;
    @(posedge PCLK); #1;
    psel_a = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h30; PWDATA = 8'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    if (pready_a === 1'b1) seen = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0; psel_a = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    if (pready_a === 1'b1) seen = 1'b1;
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_abort_pready_seen got 1 expected 0"); end
    n_checks++;
    if (pready_a !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_abort_pready got %b expected 0", pready_a); end
    n_checks++;
    if (pslverr_a !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_abort_pslverr got %b expected 0", pslverr_a); end
    n_checks++;
    if (prdata_a !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_abort_prdata got %h expected 00", prdata_a); end
    exp_q.push_back('{name: "post_rst_rd30", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(0, 1'b0, 8'h30, 8'h00, 0, 8'h00, 1'b0);
    exp_q.push_back('{name: "post_rst_rd10", ready: 3, err: 1'b0, data: 8'h00, chk: 1'b1});
    run_xfer(0, 1'b0, 8'h10, 8'h00, 0, 8'h00, 1'b0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ready !== e.ready) begin n_fail++; $display("[TB] FAIL %s ready_cycle got %0d expected %0d", e.name, o.ready, e.ready); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s pslverr got %b expected %b", e.name, o.err, e.err); end
      if (e.chk) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL %s prdata got %h expected %h", e.name, o.data, e.data); end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    PRESET   = 1'b1;
    psel_a = 1'b0; psel_b = 1'b0; psel_c = 1'b0;
    PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 8'h00;
    $display("[TB] starting apb_slave_mem bench");
    test_reset();
    test_write_read();
    test_protected();
    test_mid_change();
    test_zero_wait();
    test_illegal();
    test_back_to_back();
    test_abort();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_leftover got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB responder (completer) holding a 256 x 8 register file, built as the far end of the team's APB master bridge. One instance hangs off each of the bridge's slave selects. The top level wires the bridge's PSEL1 or PSEL2 to PSEL and PADDR[7:0] to PADDR. The block inserts a programmable number of wait states, flags write-protected and protocol-violating accesses on PSLVERR, and returns read data on PRDATA.

## Interface
- WAIT_STATES, 2: number of PREADY-low access cycles before completion; legal range 0..15.
- PROTECT_BASE, 9'd256: writes to any address >= PROTECT_BASE are refused with PSLVERR. The default protects nothing.
- PCLK  in  1  sole clock; all logic on its rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  slave select from the bridge.
- PENABLE  in  1  access phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  byte address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data, registered.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response, registered; only meaningful while PREADY = 1.

## Operation
- **Reset** (PRESET = 1 at an edge):
  - state goes to IDLE;
  - PREADY = 0, PSLVERR = 0, PRDATA = 8'h00;
  - wait counter = 0, violation flag = 0;
  - all 256 memory bytes are cleared to 8'h00.
  - Reset wins over every other event, including a transfer in progress.
- **States**: IDLE, WAIT, DONE.
- **IDLE**:
  - PSEL & !PENABLE is a setup phase. The block latches PADDR, PWRITE and PWDATA, loads cnt = WAIT_STATES and clears the violation flag.
  - If WAIT_STATES = 0 the block goes to DONE; otherwise it goes to WAIT.
  - PSEL & PENABLE with no preceding setup is an illegal access. The block goes to DONE with the violation flag set and performs no memory access.
- **WAIT**: every edge with PSEL & PENABLE:
  - cnt decrements;
  - if any of PADDR, PWRITE or PWDATA (PWDATA compared on writes only) differs from the latched value, the violation flag is set (sticky);
  - when cnt reaches 0, the block goes to DONE.
- **Entering DONE** (registered at the same edge):
  - PREADY <= 1.
  - PSLVERR <= violation | (latched write & latched addr >= PROTECT_BASE).
  - PRDATA <= mem[latched addr] for an error-free read; 8'h00 for an errored read; unchanged for writes.
- **DONE**: at the edge with PSEL & PENABLE & PREADY (completion):
  - if it is an error-free write, mem[latched addr] <= latched data;
  - PREADY <= 0, PSLVERR <= 0, state goes to IDLE.
  - Writes that carry an error leave memory unchanged.
- **Abort**: PSEL = 0 sampled in WAIT or DONE sends the block to IDLE. PREADY and PSLVERR are cleared and there is no write.
- **Restart**: PSEL & !PENABLE sampled in WAIT or DONE is treated as a fresh setup phase; the block latches the new values and restarts the counter.
- **Back-to-back**: after completion the block is in IDLE, so the bridge's ENABLE -> SETUP sequence is accepted directly with no idle cycle required.
- **PRDATA**: holds its last value outside read completions.

## Timing
- Setup edge is edge 0.
- Access cycle k is the k-th cycle with PSEL & PENABLE.
- PREADY is high in access cycle WAIT_STATES+1 and low in all earlier access cycles.
- Read data and PSLVERR are valid in the same cycle as PREADY.
- Write data reaches memory at the completion edge and is readable by the next transfer.
- Protocol checks happen only at WAIT-state edges. With WAIT_STATES = 0, signal changes are not detected and the latched values are used.
- Illegal access (no setup): PREADY = PSLVERR = 1 in the cycle after the offending edge.
- Minimum transfer: 2 cycles (setup + 1 access). Throughput is one transfer per WAIT_STATES+2 cycles.

## Test plan
- **Reset**: hold PRESET = 1 for 2 cycles, mid-stream -> PREADY = 0, PSLVERR = 0, PRDATA = 8'h00. A subsequent read of 8'h10 returns 8'h00.
- **Write then read**, WAIT_STATES = 2: write 8'hA5 to 8'h10, then read 8'h10 -> PREADY low in access cycles 1-2 and high in cycle 3 of each transfer. The read returns PRDATA = 8'hA5 with PSLVERR = 0.
- **Protected write**, PROTECT_BASE = 9'h0F0: write 8'h3C to 8'hF4 -> PREADY = 1 with PSLVERR = 1. A following read of 8'hF4 returns 8'h00 with PSLVERR = 0.
- **Mid-transfer change**, WAIT_STATES = 3: write 8'h77 to 8'h20, and change PADDR to 8'h21 in access cycle 2 -> PSLVERR = 1 at completion. Reads of 8'h20 and 8'h21 both return 8'h00.
- **Illegal access**: from IDLE drive PSEL = PENABLE = 1, PWRITE = 0 -> the next cycle shows PREADY = 1, PSLVERR = 1, PRDATA = 8'h00.
- **Abort**: drop PSEL in access cycle 1 of a write of 8'h55 to 8'h30 -> PREADY never rises and a read of 8'h30 returns 8'h00. Repeat the same write with PRESET asserted mid-WAIT -> identical result, and all outputs return to their reset values.
